sevseg_update_ctrl: RTL
=======================

SEVSEG_UPDATE_CTRL -- requirements
Module: sevseg_update_ctrl

Interface
REQ-001 SHALL provide one clock and one asynchronous, active-high reset; no other clock or reset ports.
REQ-002 SHALL have port clk, input, 1 bit: sole clock, all state on rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port address, input, 2 bits: slave register select (0 VALUE, 1 CTRL, 2 STATUS, 3 REFRESH).
REQ-005 SHALL have port chipselect, input, 1 bit: slave select.
REQ-006 SHALL have port write_n, input, 1 bit: active-low slave write strobe.
REQ-007 SHALL have port writedata, input, 32 bits: slave write data.
REQ-008 SHALL have port readdata, output, 32 bits: slave read data, combinational, zero wait states.
REQ-009 SHALL have port m_digit, output, 2 bits: index of the target digit PIO (0 = rightmost).
REQ-010 SHALL have port m_write, output, 1 bit: master write request.
REQ-011 SHALL have port m_writedata, output, 7 bits: segment pattern, active-low, bit0 = a … bit6 = g.
REQ-012 SHALL have port m_waitrequest, input, 1 bit: write is accepted in a cycle where m_write=1 and m_waitrequest=0.

Function
REQ-013 Registers SHALL be: VALUE[15:0] (four hex nibbles, nibble k -> digit k), CTRL[1:0] (bit0 EN, bit1 BLANKLZ), STATUS (bit0 BUSY, bit1 PENDING, read-only), REFRESH (write-only, reads 0).
REQ-014 A slave write SHALL occur when chipselect=1 and write_n=0; unused writedata bits SHALL be ignored, and unused readdata bits SHALL read 0.
REQ-015 An update request SHALL be raised by any write to VALUE (even with an unchanged value) or to REFRESH, and by a 0->1 transition of EN.
REQ-016 FSM states SHALL be IDLE and SEND; a 2-bit digit counter SHALL sequence digits 0,1,2,3.
REQ-017 In IDLE with EN=1 and a request (new or PENDING), the block SHALL snapshot VALUE and BLANKLZ, clear PENDING, and enter SEND with counter=0 on the next edge.
REQ-018 In SEND, m_write SHALL be 1, m_digit SHALL equal the counter, and m_writedata SHALL be the decode of snapshot nibble[counter]; outputs SHALL hold stable while m_waitrequest=1.
REQ-019 On acceptance the counter SHALL increment; acceptance of digit 3 SHALL return the FSM to IDLE with m_write=0 in the following cycle.
REQ-020 Latency: with m_waitrequest=0, a VALUE write in cycle N SHALL yield digit writes in cycles N+1..N+4 and BUSY=0 in cycle N+5.
REQ-021 BUSY SHALL be 1 exactly while the FSM is in SEND.
REQ-022 An update request during SEND, including in the cycle digit 3 is accepted, SHALL set PENDING; the running sequence SHALL continue from its snapshot, and a new sequence SHALL start on the first IDLE cycle.
REQ-023 Clearing EN during SEND SHALL NOT abort the sequence; in IDLE with EN=0, PENDING SHALL be retained and no sequence SHALL start.
REQ-024 Decode SHALL be (hex in, pattern hex out): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 B:03 C:46 D:21 E:06 F:0E.
REQ-025 With BLANKLZ=1, digit k (k=3..1) SHALL send 7F when snapshot nibbles k..3 are all zero; digit 0 SHALL never be blanked.
REQ-026 If EN=1 and a request occur in the same cycle, the sequence SHALL start next cycle per REQ-017.

Reset
REQ-027 While reset=1, asynchronously: FSM=IDLE, counter=0, VALUE=0, CTRL=0, PENDING=0, m_write=0, m_digit=0, m_writedata=7F.
REQ-028 Reset asserted mid-SEND SHALL abort immediately with no further m_write, and no sequence SHALL start after release until a new request arrives.

Verification
REQ-029 Set EN=1 (this raises a request), wait for idle, write VALUE=0x12AF, waitrequest=0 -> digit writes (0,0E),(1,08),(2,24),(3,79) in four consecutive cycles, then BUSY=0.
REQ-030 Hold m_waitrequest=1 for 3 cycles on digit 1 -> m_digit=1 and m_writedata stable for 4 cycles, then digit 2 follows.
REQ-031 Write VALUE=0x0007 with BLANKLZ=1 and EN=1 -> patterns 78,7F,7F,7F; with BLANKLZ=0 -> 78,40,40,40.
REQ-032 Write VALUE=0x1111 and then 0x2222 while the first sequence is at digit 2 -> four writes of 79, PENDING=1, then immediately four writes of 24.
REQ-033 EN=0, write VALUE=0x5555 -> no m_write, PENDING=1; set EN=1 -> four writes of 12.
REQ-034 Assert reset during digit 1 of a sequence -> m_write=0 in the same cycle, all registers read 0, and m_write stays 0 after release.

Source files
------------

// File: rtl/sevseg_update_ctrl.sv
//==============================================================================
// Module  : sevseg_update_ctrl
// Brief   : Memory-mapped 4-digit hex display controller that pushes decoded
//           segment patterns to per-digit PIOs over a simple write master.
// Rev     : 1.0
//==============================================================================
`default_nettype none

module sevseg_update_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [1:0]  m_digit,
    output logic        m_write,
    output logic [6:0]  m_writedata,
    input  logic        m_waitrequest
);

    localparam logic [1:0] ADDR_VALUE   = 2'd0;
    localparam logic [1:0] ADDR_CTRL    = 2'd1;
    localparam logic [1:0] ADDR_STATUS  = 2'd2;
    localparam logic [1:0] ADDR_REFRESH = 2'd3;
    localparam logic [6:0] SEG_BLANK    = 7'h7F;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [15:0] value_q, value_d;
    logic        en_q, en_d;
    logic        blz_q, blz_d;
    logic        pending_q, pending_d;
    logic [15:0] snap_q, snap_d;
    logic        snap_blz_q, snap_blz_d;

    logic        w_wr;
    logic        w_req;
    logic        w_busy;
    logic [3:0]  w_nib;
    logic        w_blank;
    logic        w_unused_wdata;

    assign w_unused_wdata = &{1'b0, writedata[31:16]};

    assign w_wr  = chipselect && !write_n;
    // Only a rising edge of EN counts as a request; rewriting EN=1 does not.
    assign w_req = w_wr && ((address == ADDR_VALUE) || (address == ADDR_REFRESH) ||
                            ((address == ADDR_CTRL) && writedata[0] && !en_q));
    assign w_busy = (state_q == ST_SEND);

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0: pat = 7'h40;
            4'h1: pat = 7'h79;
            4'h2: pat = 7'h24;
            4'h3: pat = 7'h30;
            4'h4: pat = 7'h19;
            4'h5: pat = 7'h12;
            4'h6: pat = 7'h02;
            4'h7: pat = 7'h78;
            4'h8: pat = 7'h00;
            4'h9: pat = 7'h10;
            4'hA: pat = 7'h08;
            4'hB: pat = 7'h03;
            4'hC: pat = 7'h46;
            4'hD: pat = 7'h21;
            4'hE: pat = 7'h06;
            default: pat = 7'h0E;
        endcase
        return pat;
    endfunction

    always_comb begin
        w_nib   = snap_q[3:0];
        w_blank = 1'b0;
        case (cnt_q)
            2'd0: begin
                w_nib   = snap_q[3:0];
                w_blank = 1'b0;
            end
            2'd1: begin
                w_nib   = snap_q[7:4];
                w_blank = (snap_q[15:4] == 12'd0);
            end
            2'd2: begin
                w_nib   = snap_q[11:8];
                w_blank = (snap_q[15:8] == 8'd0);
            end
            default: begin
                w_nib   = snap_q[15:12];
                w_blank = (snap_q[15:12] == 4'd0);
            end
        endcase
    end

    assign m_write     = w_busy;
    assign m_digit     = cnt_q;
    assign m_writedata = !w_busy               ? SEG_BLANK :
                         (snap_blz_q && w_blank) ? SEG_BLANK : seg_decode(w_nib);

    always_comb begin
        readdata = 32'd0;
        case (address)
            ADDR_VALUE:  readdata[15:0] = value_q;
            ADDR_CTRL:   readdata[1:0]  = {blz_q, en_q};
            ADDR_STATUS: readdata[1:0]  = {pending_q, w_busy};
            default:     readdata       = 32'd0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        value_d    = value_q;
        en_d       = en_q;
        blz_d      = blz_q;
        pending_d  = pending_q;
        snap_d     = snap_q;
        snap_blz_d = snap_blz_q;

        if (w_wr) begin
            case (address)
                ADDR_VALUE: value_d = writedata[15:0];
                ADDR_CTRL: begin
                    en_d  = writedata[0];
                    blz_d = writedata[1];
                end
                default: ;
            endcase
        end

        // Post-write register values are used so a same-cycle write starts next cycle.
        case (state_q)
            ST_IDLE: begin
                if (en_d && (w_req || pending_q)) begin
                    snap_d     = value_d;
                    snap_blz_d = blz_d;
                    pending_d  = 1'b0;
                    cnt_d      = 2'd0;
                    state_d    = ST_SEND;
                end else if (w_req) begin
                    pending_d = 1'b1;
                end
            end
            default: begin
                if (w_req) begin
                    pending_d = 1'b1;
                end
                if (!m_waitrequest) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 2'd0;
            value_q    <= 16'd0;
            en_q       <= 1'b0;
            blz_q      <= 1'b0;
            pending_q  <= 1'b0;
            snap_q     <= 16'd0;
            snap_blz_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            value_q    <= value_d;
            en_q       <= en_d;
            blz_q      <= blz_d;
            pending_q  <= pending_d;
            snap_q     <= snap_d;
            snap_blz_q <= snap_blz_d;
        end
    end

endmodule

`default_nettype wire
